div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider with its own sequencing FSM.
- Services the EX stage's DIV/DIVU handshake: EX holds start high and stalls the pipeline until ready.
- Produces {remainder, quotient}, which EX writes to {HI, LO}.
- Supports annul, so a flushed divide aborts cleanly.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  in  WIDTH  dividend; sampled when start is accepted.
- opdata2_i  in  WIDTH  divisor; sampled when start is accepted.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  abort the current operation (pipeline flush).
- result_o  out  2*WIDTH  [2W-1:W] = remainder, [W-1:0] = quotient.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst low, async): state = IDLE, ready_o = 0, result_o = 0, counter = 0, internal registers = 0. Reset mid-operation discards all progress.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - Waits for start_i=1 and annul_i=0.
  - If opdata2_i == 0, go to DIVZERO.
  - Otherwise go to ON. Latch |dividend| and |divisor|; the absolute value is taken only when signed_div_i=1 and bit W-1 is set. Latch signed_div_i, both operand sign bits, and clear counter and partial remainder.
- DIVZERO: one cycle. Result forced to 0, then go to END.
- ON: one restoring iteration per cycle.
  - Shift {rem, dividend} left by 1.
  - Trial subtract divisor from rem. If no borrow, rem = difference and shift in quotient bit 1; else shift in 0.
  - Counter increments each cycle. After WIDTH iterations, go to END.
  - Sign fix-up is applied when entering END:
    - quotient negated if signed and sign1 ^ sign2;
    - remainder negated if signed and sign1 (remainder takes the dividend's sign).
  - 0x80000000 / -1 signed: quotient wraps to 0x80000000, remainder 0. No exception.
- END:
  - ready_o = 1 and result_o valid, both registered outputs.
  - Stays in END while start_i=1.
  - When start_i=0, go to IDLE; ready_o = 0 and result_o = 0 on the next edge.
- Latency:
  - Start sampled at edge E0; ready_o = 1 after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - Divide-by-zero: ready_o after edge E0+2.
- annul_i:
  - In ON or DIVZERO: go to IDLE next edge; ready_o stays 0; result_o = 0.
  - In IDLE: blocks acceptance of start.
  - In END: go to IDLE, clearing ready_o.
  - annul_i takes priority over start_i in every state.
- Operand changes after acceptance are ignored until the next IDLE acceptance.
- start_i deasserted during ON is ignored; the operation runs to completion.

Optional Feature:
- Macro: DIV_FAST_EN.
- When defined, IDLE checks whether |dividend| < |divisor| (divisor nonzero).
  - If so, go straight to END.
  - Quotient = 0; remainder = original dividend, keeping its sign.
  - ready_o after edge E0+1.
- When undefined, every nonzero divide takes the full WIDTH+1 cycles; results are identical in both builds.

Test Plan:
- Unsigned 100 / 7, start held → after 33 cycles ready_o=1, result_o = {0x00000002, 0x0000000E}; drop start → ready_o=0 and result_o=0 on the next edge.
- Signed 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 with dividend 0x12345678 → ready_o=1 two cycles after start, result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at iteration 10 of 100/7 → IDLE next edge, ready_o never asserts. A following 50/5 yields quotient 10, remainder 0 in 33 cycles. rst pulled low mid-op → all outputs 0 immediately (async).
- DIV_FAST_EN build: unsigned 3 / 10 → ready_o one cycle after start, result_o = {0x00000003, 0x00000000}. Non-fast build: same result after 33 cycles.

Source files
------------

// File: rtl/div_unit_if.sv
// EX <-> divider handshake bundle: operands and start/annul in, result/ready out.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i,
    output start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i,
    input  start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, result = {remainder, quotient}.
// Define DIV_FAST_EN to finish immediately when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_DIVZERO, S_ON, S_END
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               rdy_q, rdy_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic             neg_a, neg_b;
  logic [WIDTH:0]   shift, sub;
  logic             ge;
  logic [WIDTH-1:0] rem_it, quo_it;

  assign neg_a = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign neg_b = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign a_abs = neg_a ? -bus.opdata1_i : bus.opdata1_i;
  assign b_abs = neg_b ? -bus.opdata2_i : bus.opdata2_i;

  // One restoring step: rem < dsr beforehand, so the difference fits WIDTH bits
  assign shift  = {rem_q, quo_q[WIDTH-1]};
  assign ge     = shift >= {1'b0, dsr_q};
  assign sub    = shift - {1'b0, dsr_q};
  assign rem_it = ge ? sub[WIDTH-1:0] : shift[WIDTH-1:0];
  assign quo_it = {quo_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    rdy_d   = 1'b0;
    res_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          sgn_d = bus.signed_div_i;
          s1_d  = bus.opdata1_i[WIDTH-1];
          s2_d  = bus.opdata2_i[WIDTH-1];
          cnt_d = '0;
          rem_d = '0;
          quo_d = a_abs;
          dsr_d = b_abs;
          if (bus.opdata2_i == '0) begin
            state_d = S_DIVZERO;
`ifdef DIV_FAST_EN
          end else if (a_abs < b_abs) begin
            quo_d   = '0;
            rem_d   = bus.opdata1_i;
            state_d = S_END;
`endif
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = '0;
          quo_d   = '0;
          state_d = S_END;
        end
      end
      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_it;
          quo_d = quo_it;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Remainder follows the dividend's sign
            quo_d   = (sgn_q & (s1_q ^ s2_q)) ? -quo_it : quo_it;
            rem_d   = (sgn_q & s1_q) ? -rem_it : rem_it;
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d = S_IDLE;
        end else begin
          rdy_d = 1'b1;
          res_d = {rem_q, quo_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      rdy_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      rdy_q   <= rdy_d;
      res_q   <= res_d;
    end
  end

  assign bus.ready_o  = rdy_q;
  assign bus.result_o = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, annul, async reset and the fast path.
module tb_div_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_FAST_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 33;
`endif

  task automatic run_div(
    input string       nm,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          lat,
    input logic [63:0] exp_res,
    input logic        hold
  );
    int n;
    n = 0;
    @(negedge clk);
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.opdata1_i    = 32'hDEAD_BEEF;
        bus.opdata2_i    = 32'h0000_0003;
        bus.signed_div_i = ~sg;
      end
    end while (!bus.ready_o && n < 60);
    tests++;
    if (!bus.ready_o || (n - 1) != lat) begin
      fails++;
      $display("FAIL %s latency: got %0d ready=%b, want %0d",
               nm, n - 1, bus.ready_o, lat);
    end
    tests++;
    if (bus.result_o !== exp_res) begin
      fails++;
      $display("FAIL %s result: got %h, want %h", nm, bus.result_o, exp_res);
    end
    if (hold) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp_res) begin
        fails++;
        $display("FAIL %s hold: got ready=%b res=%h, want 1 %h",
                 nm, bus.ready_o, bus.result_o, exp_res);
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL %s release: got ready=%b res=%h, want 0 0",
               nm, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset ready: got %b, want 0", bus.ready_o);
    end
    tests++;
    if (bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL reset result: got %h, want 0", bus.result_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned;
    run_div("u100_7", 1'b0, 32'd100, 32'd7, 33,
            {32'h2, 32'hE}, 1'b1);
    run_div("uFFFF_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 33,
            {32'h0, 32'hFFFF_FFFF}, 1'b0);
  endtask

  task automatic test_signed;
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 33,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_div("s7_-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 33,
            {32'h1, 32'hFFFF_FFFD}, 1'b0);
    run_div("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            {32'h0, 32'h8000_0000}, 1'b0);
  endtask

  task automatic test_divzero;
    run_div("divzero", 1'b0, 32'h1234_5678, 32'h0, 2,
            64'h0, 1'b0);
  endtask

  task automatic test_fast;
    run_div("fast3_10", 1'b0, 32'd3, 32'd10, FAST_LAT,
            {32'h3, 32'h0}, 1'b0);
    run_div("fast-3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, FAST_LAT,
            {32'hFFFF_FFFD, 32'h0}, 1'b0);
  endtask

  task automatic test_annul;
    int seen;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    tests++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL annul_on: got ready=%b res=%h, want 0 0",
               bus.ready_o, bus.result_o);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL annul_quiet: got %0d ready cycles, want 0", seen);
    end
    // annul held with start must block acceptance
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen++;
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL annul_idle: got %0d ready cycles, want 0", seen);
    end
    run_div("after_annul", 1'b0, 32'd50, 32'd5, 33,
            {32'h0, 32'd10}, 1'b0);
  endtask

  task automatic test_rst_mid;
    int n;
    n = 0;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready_o && n < 60);
    tests++;
    if (bus.ready_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: got ready=%b, want 1", bus.ready_o);
    end
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL rst_async: got ready=%b res=%h, want 0 0",
               bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("after_rst", 1'b0, 32'd50, 32'd5, 33,
            {32'h0, 32'd10}, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_fast();
    test_annul();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
